// File: rtl/sr_floatb_delay.sv
// FLOATB conversion of the reconstructed signal SR plus the SR1/SR2 delay pair.
// An iterative normalizer shifts the magnitude left one bit per clock until its MSB reaches bit 14.
module sr_floatb_delay #(
    parameter logic [10:0] SR_RESET = 11'h020
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] sr_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [10:0] sr0,
    output logic [10:0] sr1,
    output logic [10:0] sr2,
    output logic        out_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        NORM = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nx;
    logic        sign_r;
    logic [14:0] mag_r;
    logic [3:0]  exp_r;
    logic        accept;
    logic        finish;
    logic [10:0] result;
    logic [15:0] neg_in;
    logic [14:0] mag_in;

    // The 0x8000 case wraps back to itself; masking to 15 bits gives magnitude 0.
    assign neg_in   = ~sr_in + 16'd1;
    assign mag_in   = sr_in[15] ? neg_in[14:0] : sr_in[14:0];
    assign in_ready = (state_r == IDLE);

    always_comb begin
        state_nx = state_r;
        accept   = 1'b0;
        finish   = 1'b0;
        result   = {sign_r, exp_r, mag_r[14:9]};
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = NORM;
                end
            end
            NORM: begin
                if (mag_r == '0) begin
                    finish   = 1'b1;
                    result   = {sign_r, 4'd0, 6'd32};
                    state_nx = IDLE;
                end else if (mag_r[14]) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            sign_r    <= 1'b0;
            mag_r     <= '0;
            exp_r     <= '0;
            sr0       <= SR_RESET;
            sr1       <= SR_RESET;
            sr2       <= SR_RESET;
            out_valid <= 1'b0;
        end else begin
            state_r   <= state_nx;
            out_valid <= finish;
            if (accept) begin
                sign_r <= sr_in[15];
                mag_r  <= mag_in;
                exp_r  <= 4'd15;
            end else if (state_r == NORM && !finish) begin
                mag_r <= mag_r << 1;
                exp_r <= exp_r - 4'd1;
            end
            if (finish) begin
                sr0 <= result;
                sr1 <= result;
                sr2 <= sr1;
            end
        end
    end

endmodule

// File: tb/tb_sr_floatb_delay.sv
// Randomized bench for sr_floatb_delay against an arithmetic FLOATB/delay-line reference.
module tb_sr_floatb_delay;

    logic        test_clk = 1'b0;
    logic        reset_n;
    logic [15:0] sr_in;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] sr0;
    logic [10:0] sr1;
    logic [10:0] sr2;
    logic        out_valid;

    int checks = 0;
    int errors = 0;
    int m_sr0, m_sr1, m_sr2;

    sr_floatb_delay #(.SR_RESET(11'h020)) dut (
        .clk      (test_clk),
        .reset_n  (reset_n),
        .sr_in    (sr_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sr0      (sr0),
        .sr1      (sr1),
        .sr2      (sr2),
        .out_valid(out_valid)
    );

    always #5 test_clk = ~test_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_mag(input logic [15:0] v);
        int x;
        x = v;
        if (v[15]) return (65536 - x) & 32'h7FFF;
        return x & 32'h7FFF;
    endfunction

    function automatic int ref_msb(input int mag);
        int k;
        k = -1;
        for (int i = 0; i < 15; i++)
            if ((mag >> i) & 1) k = i;
        return k;
    endfunction

    function automatic int ref_float(input logic [15:0] v);
        int mag, e, m;
        mag = ref_mag(v);
        if (mag == 0) begin
            e = 0;
            m = 32;
        end else begin
            e = ref_msb(mag) + 1;
            m = (mag << 6) >> e;
        end
        return (int'(v[15]) << 10) | (e << 6) | m;
    endfunction

    function automatic int ref_latency(input logic [15:0] v);
        int mag;
        mag = ref_mag(v);
        if (mag == 0) return 1;
        return 15 - ref_msb(mag);
    endfunction

    // Called at a falling edge with the DUT expected idle; returns at the falling edge of the out_valid cycle.
    task automatic send(input logic [15:0] v, input bit garbage);
        int  lat;
        bit  hold_ok;
        int  exp_res;
        int  exp_lat;
        exp_res = ref_float(v);
        exp_lat = ref_latency(v);
        check("in_ready_idle", in_ready, 1);
        sr_in    = v;
        in_valid = 1'b1;
        @(posedge test_clk);
        @(negedge test_clk);
        in_valid = garbage;
        sr_in    = 16'($urandom);
        hold_ok  = 1'b1;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready !== 1'b0 || sr0 !== 11'(m_sr0) || sr1 !== 11'(m_sr1) || sr2 !== 11'(m_sr2))
                hold_ok = 1'b0;
            @(negedge test_clk);
            lat++;
            if (garbage) sr_in = 16'($urandom);
        end
        check("busy_hold", hold_ok, 1);
        m_sr2 = m_sr1;
        m_sr1 = exp_res;
        m_sr0 = exp_res;
        check("latency", lat, exp_lat);
        check("out_valid", out_valid, 1);
        check("sr0", sr0, m_sr0);
        check("sr1", sr1, m_sr1);
        check("sr2", sr2, m_sr2);
        check("in_ready_done", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            @(negedge test_clk);
            check("pulse_width", out_valid, 0);
            repeat (n - 1) @(negedge test_clk);
        end
    endtask

    initial begin
        logic [15:0] directed [6];
        logic [15:0] chain [3];
        logic [15:0] v;
        bit          seen;

        directed = '{16'h0000, 16'h8000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h0100};
        chain    = '{16'h0001, 16'h7FFF, 16'h0100};

        reset_n  = 1'b0;
        in_valid = 1'b0;
        sr_in    = '0;
        repeat (2) @(negedge test_clk);
        check("rst_sr0", sr0, 11'h020);
        check("rst_sr1", sr1, 11'h020);
        check("rst_sr2", sr2, 11'h020);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;
        @(negedge test_clk);

        // Reset two cycles into a long conversion must abandon it.
        sr_in    = 16'h0001;
        in_valid = 1'b1;
        @(posedge test_clk);
        @(negedge test_clk);
        in_valid = 1'b0;
        @(negedge test_clk);
        reset_n = 1'b0;
        @(negedge test_clk);
        reset_n = 1'b1;
        check("abort_in_ready", in_ready, 1);
        check("abort_sr0", sr0, 11'h020);
        seen = 1'b0;
        repeat (20) begin
            @(negedge test_clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_pulse", seen, 0);
        check("abort_sr1", sr1, 11'h020);
        check("abort_sr2", sr2, 11'h020);
        m_sr0 = 32'h020;
        m_sr1 = 32'h020;
        m_sr2 = 32'h020;

        foreach (directed[i]) begin
            send(directed[i], directed[i] == 16'h0100);
            idle(1);
        end

        // Back-to-back with in_valid held high: each accept lands in the out_valid cycle.
        foreach (chain[i]) send(chain[i], 1'b1);
        idle(2);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0:       v = 16'($urandom_range(0, 3));
                1:       v = 16'hFFFF - 16'($urandom_range(0, 3));
                2:       v = 16'h8000 + 16'($urandom_range(0, 1));
                3:       v = 16'h7FFF - 16'($urandom_range(0, 1));
                default: v = 16'($urandom);
            endcase
            send(v, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
